dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the `pipeline1` CPU: it is the slave end of the pipeline's load/store port. It accepts one request at a time over a valid/ready handshake and models a word-organised RAM with byte enables and a programmable number of wait states. It returns a single-cycle response carrying read data and an error flag. The MEM stage issues loads and stores to it and stalls until the response arrives.

## Interface
- `ADDR_WIDTH`, 10: word-address width; memory holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: wait states between acceptance and response, legal range 0–15.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: reset; synchronous and active-high.
- `req_valid` input 1: request present; its fields must be held stable until accepted.
- `req_ready` output 1: responder can accept a request this cycle.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address; bits [1:0] are ignored and the word index is bits [ADDR_WIDTH+1:2].
- `req_wdata` input 32: store data, lane-aligned (byte lane i is bits [8i+7:8i]).
- `req_be` input 4: byte-lane enables for stores; ignored for loads.
- `resp_valid` output 1: one-cycle response strobe.
- `resp_rdata` output 32: full word read; valid only when `resp_valid` is high.
- `resp_err` output 1: request failed; valid only when `resp_valid` is high.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch we/addr/wdata/be.
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - `req_ready`=0.
  - Decrement the counter each cycle.
  - When the counter reaches 1, the next edge goes to RESP.
- Commit edge (the edge that enters RESP):
  - Error if `req_addr[31:ADDR_WIDTH+2]` ≠ 0 (out of range).
  - Error on a store with `req_be`=4'b0000.
  - An errored store writes nothing; an errored load returns `resp_rdata`=0.
  - A valid store updates only the enabled lanes. `resp_rdata` returns the pre-write word (read-before-write).
  - A valid load returns the addressed word.
- RESP:
  - `resp_valid`=1 for exactly one cycle, `req_ready`=0.
  - Next state is always IDLE; there is no back-to-back acceptance from RESP.
- Memory contents are not cleared by reset and are X until written. Optional `$readmemh` preload is simulation-only.
- `resp_rdata` and `resp_err` hold their last values outside RESP. Checkers must ignore them when `resp_valid`=0.

## Timing
- Reset:
  - While `rst`=1: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, state=IDLE.
  - `req_ready`=1 in the first cycle after `rst` falls.
- Acceptance happens at edge k when `req_valid` and `req_ready` are both high.
- `resp_valid` is high in the cycle after edge k+WAIT_CYCLES. Latency is WAIT_CYCLES+1 cycles.
- With WAIT_CYCLES=0, the response appears in the cycle right after acceptance.
- Throughput is one request per WAIT_CYCLES+2 cycles. `req_ready` returns to 1 in the cycle after `resp_valid`.
- There is no response backpressure; the requester must always sample `resp_valid`.
- A store followed immediately by a load to the same word returns the stored data, because the commit precedes the next acceptance.
- Reset mid-operation (in WAIT or RESP): return to IDLE on that edge.
  - A pending store not yet committed is dropped.
  - No `resp_valid` is produced for the aborted request.
- `req_valid` dropping while `req_ready`=0 is legal and has no effect.
- A request is never accepted during `rst`.

## Test plan
- Reset, then load from 0x0 after storing 0xDEADBEEF with be=4'hF (WAIT_CYCLES=2). Required:
  - Each `resp_valid` appears exactly 3 cycles after its acceptance edge.
  - The load returns 0xDEADBEEF with `resp_err`=0.
- Byte enables: store 0x11223344 with be=4'b0101 to a word holding 0xAABBCCDD, then load it. The load returns 0xAA22CC44.
- Out of range: with ADDR_WIDTH=10, store 0xFFFFFFFF to 0x00001000, then load 0x00001000. Required:
  - Both responses have `resp_err`=1.
  - The load returns `resp_rdata`=0.
  - A load of word 0x0 is unchanged.
- WAIT_CYCLES=0: 4 back-to-back requests with `req_valid` held high. Required:
  - Acceptances occur every 2 cycles.
  - `req_ready` toggles 1,0,1,0.
  - Exactly 4 `resp_valid` pulses are seen.
- Reset mid-WAIT: accept a store of 0x12345678 to 0x40, assert `rst` one cycle later, then load 0x40. Required:
  - No response for the store.
  - The load returns the prior contents, not 0x12345678.
- Store with be=0: `resp_err`=1, and memory is unchanged on readback.

Source files
------------

// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : dmem_responder
// Brief    : Word-organised data-memory slave with byte enables and wait states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem_q [0:c_DEPTH-1];

    logic                  w_we;
    logic [29:0]           w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_be;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_oor;
    logic                  w_err;
    logic                  w_commit;
    logic                  w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^req_addr[1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[31:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = c_WAIT;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the commit shares the acceptance edge, so the
    // request fields come straight from the port instead of the latches.
    assign w_we     = (state_q == ST_IDLE) ? req_we         : we_q;
    assign w_addr   = (state_q == ST_IDLE) ? req_addr[31:2] : addr_q;
    assign w_wdata  = (state_q == ST_IDLE) ? req_wdata      : wdata_q;
    assign w_be     = (state_q == ST_IDLE) ? req_be         : be_q;
    assign w_idx    = w_addr[ADDR_WIDTH-1:0];
    assign w_oor    = (w_addr >> ADDR_WIDTH) != 30'd0;
    assign w_err    = w_oor || (w_we && (w_be == 4'b0000));
    assign w_commit = (state_d == ST_RESP) && (state_q != ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            if (w_commit) begin
                err_q   <= w_err;
                rdata_q <= w_err ? 32'd0 : mem_q[w_idx];
            end
        end
    end

    // Storage has no reset; the read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem_q[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp_valid = (state_q == ST_RESP) && !rst;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (2 and 0 wait states).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_we, req_ready, resp_valid, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    logic        v0, we0, ready0, rv0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (v0),
        .req_ready  (ready0),
        .req_we     (we0),
        .req_addr   (addr0),
        .req_wdata  (wdata0),
        .req_be     (be0),
        .resp_valid (rv0),
        .resp_rdata (rdata0),
        .resp_err   (err0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request on the 2-wait-state instance; lat = -1 if no response.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
        int n;
        rdata     = 32'd0;
        err       = 1'b0;
        lat       = -1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (resp_valid === 1'b1) begin
            lat   = n + 1;
            rdata = resp_rdata;
            err   = resp_err;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", resp_err); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", req_ready); end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL ready0_after_reset: got %b expected 1", ready0); end
        tick();
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL store_latency: got %0d expected 3", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err: got %b expected 0", er); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_one_cycle: got %b expected 0", resp_valid); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL load_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", er); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h8, 32'hAABBCCDD, 4'hF, rd, er, lat);
        do_req(1'b1, 32'h8, 32'h11223344, 4'b0101, rd, er, lat);
        checks++; if (rd !== 32'hAABBCCDD) begin errors++; $display("FAIL be_read_before_write: got %h expected aabbccdd", rd); end
        do_req(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL be_merge: got %h expected aa22cc44", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_store_err: got %b expected 1", er); end
        do_req(1'b0, 32'h00001000, 32'h0, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_load_err: got %b expected 1", er); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL oor_load_data: got %h expected 00000000", rd); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_word0_intact: got %h expected deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rdy_seq;
        int         acc_cyc [4];
        int         nacc;
        int         pulses;
        logic       acc;
        nacc   = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
        we0    = 1'b1;
        addr0  = 32'h10;
        wdata0 = 32'h1;
        be0    = 4'hF;
        v0     = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) rdy_seq[3-c] = ready0;
            acc = ready0 && v0;
            tick();
            if (rv0 === 1'b1) pulses++;
            if (acc) begin
                acc_cyc[nacc] = c;
                nacc++;
                if (nacc == 4) begin
                    v0 = 1'b0;
                end else begin
                    addr0  = addr0 + 32'h10;
                    wdata0 = wdata0 + 32'h1;
                end
            end
        end
        v0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rv0 === 1'b1) pulses++;
        end
        checks++; if (rdy_seq !== 4'b1010) begin errors++; $display("FAIL b2b_ready_seq: got %b expected 1010", rdy_seq); end
        checks++; if (nacc != 4) begin errors++; $display("FAIL b2b_accept_count: got %0d expected 4", nacc); end
        checks++;
        if (acc_cyc[0] != 0 || acc_cyc[1] != 2 || acc_cyc[2] != 4 || acc_cyc[3] != 6) begin
            errors++;
            $display("FAIL b2b_accept_spacing: got %0d,%0d,%0d,%0d expected 0,2,4,6",
                     acc_cyc[0], acc_cyc[1], acc_cyc[2], acc_cyc[3]);
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_resp_pulses: got %0d expected 4", pulses); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          pulses;
        do_req(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, er, lat);
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midwait_busy: got %b expected 0", req_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midwait_no_resp: got %0d pulses expected 0", pulses); end
        do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL midwait_store_dropped: got %h expected cafef00d", rd); end
    endtask

    task automatic test_be_zero();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h8, 32'h55555555, 4'b0000, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL be0_err: got %b expected 1", er); end
        do_req(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL be0_unchanged: got %h expected aa22cc44", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL be0_readback_err: got %b expected 0", er); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        v0        = 1'b0;
        we0       = 1'b0;
        addr0     = 32'd0;
        wdata0    = 32'd0;
        be0       = 4'd0;
        test_reset();
        test_store_load();
        test_byte_enables();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_wait();
        test_be_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
